// File: rtl/ctrl_pkg.sv
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE = 3'd0,
    CL_ALU  = 3'd1,
    CL_LW   = 3'd2,
    CL_SW   = 3'd3,
    CL_BNE  = 3'd4
  } class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SPEC2 = 6'b011100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_CLO = 6'h21;
  localparam logic [5:0] FN_CLZ = 6'h20;
  localparam logic [5:0] FN_MUL = 6'h02;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_CMP = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_CLO = 4'b1011;
  localparam logic [3:0] ALU_CLZ = 4'b1100;

endpackage

// File: rtl/ctrl_decode.sv
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic [3:0] alu_op,
  output logic       alu_src,
  output logic       reg_dst,
  output logic       sel_a,
  output logic       sel_b,
  output class_t     instr_class,
  output logic       illegal
);

  always_comb begin
    alu_op      = '0;
    alu_src     = 1'b0;
    reg_dst     = 1'b0;
    sel_a       = 1'b0;
    sel_b       = 1'b0;
    instr_class = CL_NONE;
    case (opcode)
      OP_RTYPE: begin
        reg_dst     = 1'b1;
        instr_class = CL_ALU;
        case (func)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_SLT: alu_op = ALU_SLT;
          FN_SLL: begin
            alu_op = ALU_SLL;
            sel_a  = 1'b1;
            sel_b  = 1'b1;
          end
          FN_SRL: begin
            alu_op = ALU_SRL;
            sel_a  = 1'b1;
            sel_b  = 1'b1;
          end
          default: begin
            reg_dst     = 1'b0;
            instr_class = CL_NONE;
          end
        endcase
      end
      OP_SPEC2: begin
        reg_dst     = 1'b1;
        instr_class = CL_ALU;
        case (func)
          FN_CLO: alu_op = ALU_CLO;
          FN_CLZ: alu_op = ALU_CLZ;
          FN_MUL: alu_op = ALU_MUL;
          default: begin
            reg_dst     = 1'b0;
            instr_class = CL_NONE;
          end
        endcase
      end
      OP_ADDI: begin
        alu_op      = ALU_ADD;
        alu_src     = 1'b1;
        instr_class = CL_ALU;
      end
      OP_ORI: begin
        alu_op      = ALU_OR;
        alu_src     = 1'b1;
        instr_class = CL_ALU;
      end
      OP_LW: begin
        alu_op      = ALU_ADD;
        alu_src     = 1'b1;
        instr_class = CL_LW;
      end
      OP_SW: begin
        alu_op      = ALU_ADD;
        alu_src     = 1'b1;
        instr_class = CL_SW;
      end
      OP_BNE: begin
        alu_op      = ALU_CMP;
        instr_class = CL_BNE;
      end
      default: instr_class = CL_NONE;
    endcase
    illegal = (instr_class == CL_NONE);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       sel_a,
  output logic       sel_b,
  output logic [3:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
);

  state_t     cur, nxt;
  class_t     cls_q;

  logic [3:0] dec_alu_op;
  logic       dec_alu_src, dec_reg_dst, dec_sel_a, dec_sel_b, dec_illegal;
  class_t     dec_class;

  ctrl_decode u_decode (
    .opcode      (opcode),
    .func        (func),
    .alu_op      (dec_alu_op),
    .alu_src     (dec_alu_src),
    .reg_dst     (dec_reg_dst),
    .sel_a       (dec_sel_a),
    .sel_b       (dec_sel_b),
    .instr_class (dec_class),
    .illegal     (dec_illegal)
  );

  assign state = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= ST_FETCH;
    else        cur <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op  <= '0;
      alu_src <= 1'b0;
      reg_dst <= 1'b0;
      sel_a   <= 1'b0;
      sel_b   <= 1'b0;
      cls_q   <= CL_NONE;
    end else if (cur == ST_DECODE) begin
      alu_op  <= dec_alu_op;
      alu_src <= dec_alu_src;
      reg_dst <= dec_reg_dst;
      sel_a   <= dec_sel_a;
      sel_b   <= dec_sel_b;
      cls_q   <= dec_class;
    end
  end

  // Strobes are decoded from state; gating on rst_n makes reset drop them
  // without waiting for the state flop to settle through a clock.
  always_comb begin
    nxt           = ST_FETCH;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    if (rst_n) begin
      case (cur)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            nxt      = ST_DECODE;
          end else begin
            nxt = ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (dec_illegal) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            nxt        = ST_FETCH;
          end else begin
            nxt = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CL_BNE: begin
              pc_write_cond = ~zero;
              instr_done    = 1'b1;
              nxt           = ST_FETCH;
            end
            CL_LW, CL_SW: nxt = ST_MEM;
            CL_ALU:       nxt = ST_WB;
            default:      nxt = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (cls_q == CL_LW) begin
            mem_read = 1'b1;
            nxt      = mem_ready ? ST_WB : ST_MEM;
          end else if (cls_q == CL_SW) begin
            mem_write = 1'b1;
            if (mem_ready) begin
              instr_done = 1'b1;
              nxt        = ST_FETCH;
            end else begin
              nxt = ST_MEM;
            end
          end else begin
            nxt = ST_FETCH;
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          mem_to_reg = (cls_q == CL_LW);
          nxt        = ST_FETCH;
        end
        default: nxt = ST_FETCH;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 opcode  in  6  instruction[31:26], valid from the DECODE state onward.
REQ-004 func  in  6  instruction[5:0], valid from the DECODE state onward.
REQ-005 zero  in  1  ALU zero flag, sampled in the EXEC state.
REQ-006 mem_ready  in  1  memory handshake; completes the current memory access in the cycle it is high.
REQ-007 mem_read, mem_write  out  1 each  memory access strobes; each is held until mem_ready.
REQ-008 ir_write, pc_write, pc_write_cond  out  1 each  IR load, unconditional PC load, branch PC load.
REQ-009 reg_write, reg_dst, alu_src, mem_to_reg, sel_a, sel_b  out  1 each  datapath controls with the existing single-cycle meanings.
REQ-010 alu_op  out  4  ALU function code.
REQ-011 instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
REQ-012 illegal  out  1  one-cycle pulse when the decoded opcode/func pair is unsupported.
REQ-013 state  out  3  current state encoding, for debug.

Function
REQ-014 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; all other encodings go to FETCH on the next edge.
REQ-015 FETCH: mem_read=1; on mem_ready, ir_write=1 and pc_write=1 (PC+4) in that cycle, next state DECODE; otherwise stay in FETCH.
REQ-016 DECODE: one cycle; register alu_op, alu_src, reg_dst, sel_a and sel_b from opcode/func, next state EXEC. An illegal pair pulses illegal and instr_done and returns to FETCH.
REQ-017 Decode table (alu_op, alu_src, sel_a/sel_b):
- R-type (op 000000): add 20h -> 0000; sub 22h -> 0001; and 24h -> 0011; or 25h -> 0100; slt 2Ah -> 0101; all with alu_src=0 and reg_dst=1.
- Shifts (op 000000): sll 00h -> 1000; srl 02h -> 1010; both with alu_src=0, sel_a=sel_b=1.
- op 011100: clo 21h -> 1011; clz 20h -> 1100; mul 02h -> 0010; all with reg_dst=1.
- addi 001000 -> 0000; ori 001101 -> 0100; lw 100011 -> 0000; sw 101011 -> 0000; all with alu_src=1 and reg_dst=0.
- bne 000101 -> 0111 with alu_src=0.
REQ-018 The registered decode outputs hold constant from EXEC through the end of the instruction.
REQ-019 EXEC: R-type, shift, 011100-type, addi and ori go to WB; lw and sw go to MEM.
REQ-020 EXEC for bne: pc_write_cond=1 when zero=0, instr_done=1, next state FETCH.
REQ-021 MEM for lw: mem_read=1 until mem_ready, then go to WB with mem_to_reg=1.
REQ-022 MEM for sw: mem_write=1 until mem_ready, then pulse instr_done and go to FETCH. reg_write is never asserted for sw.
REQ-023 WB: reg_write=1 for exactly one cycle, instr_done=1, next state FETCH; mem_to_reg=1 only for lw.
REQ-024 With mem_ready tied high, latency is: R/I-type 4 cycles, lw 5 cycles, sw 4 cycles, bne 3 cycles. Each cycle mem_ready is low adds one cycle.
REQ-025 Strobes not listed for a state are 0 in that state. mem_read and mem_write are never high together.
REQ-026 mem_ready is ignored outside FETCH and MEM.

Reset
REQ-027 rst_n low forces state=FETCH and all outputs to 0, including the registered decode fields, immediately and independent of clk.
REQ-028 Reset mid-access (for example in MEM) drops mem_read/mem_write asynchronously. No write completes and no instr_done is issued.
REQ-029 After rst_n deasserts, the first rising edge evaluates FETCH with mem_read=1.

Structure
REQ-030 A shared package ctrl_pkg holds the state encodings, the opcode and func constants, and the alu_op codes.
REQ-031 Decode is a combinational sub-module ctrl_decode (opcode, func -> alu_op, alu_src, reg_dst, sel_a, sel_b, class, illegal). The FSM registers its outputs in DECODE.

Verification
REQ-032 add (op 0, func 20h) with mem_ready=1 -> states 0,1,2,4; alu_op=0000; reg_write=1 only in cycle 4; instr_done in cycle 4.
REQ-033 lw with mem_ready low for 2 cycles in MEM -> mem_read held for 3 MEM cycles, then WB with mem_to_reg=1 and reg_write=1; total 7 cycles.
REQ-034 bne: zero=0 -> pc_write_cond=1 in EXEC. Repeat with zero=1 -> pc_write_cond=0. Both cases return to FETCH after 3 cycles with reg_write never 1.
REQ-035 opcode 111111 -> illegal and instr_done pulse in DECODE, next state FETCH, no reg_write or mem_write.
REQ-036 sw with rst_n pulsed low while in MEM and mem_ready=0 -> mem_write=0 immediately, state=FETCH, no instr_done; the next fetch proceeds normally.
REQ-037 sll (op 0, func 00h) -> alu_op=1000, sel_a=sel_b=1, alu_src=0, all held through WB.
